// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, prot type and the outstanding-count helper.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Wide enough for the largest supported MAX_OUT (15).
    localparam int unsigned OUT_CNT_W = 4;

    typedef logic [2:0] axi_prot_t;

    // Accept and response in the same cycle cancel; a stray response never underflows.
    function automatic logic [OUT_CNT_W-1:0] next_outstanding(
        input logic [OUT_CNT_W-1:0] cur,
        input logic                 inc,
        input logic                 dec
    );
        if (inc && !dec) begin
            return cur + OUT_CNT_W'(1);
        end
        if (dec && !inc && (cur != '0)) begin
            return cur - OUT_CNT_W'(1);
        end
        return cur;
    endfunction

endpackage

// File: rtl/axi4_lite_hold_reg.sv
// Payload register with pend flag: loads on local accept, clears on the AXI handshake.
module axi4_lite_hold_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             handshake,
    output logic             pend,
    output logic [WIDTH-1:0] data
);

    logic             pend_q, pend_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        pend_d = pend_q;
        data_d = data_q;
        if (load) begin
            pend_d = 1'b1;
            data_d = load_data;
        end else if (handshake) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    assign pend = pend_q;
    assign data = data_q;

endmodule

// File: rtl/axi4_lite_master_bridge.sv
// Valid/ready command/response to AXI4-Lite master bridge with bounded outstanding count.
// Optional watchdog flags enabled by defining AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_master_bridge
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_OUT        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned STRB_W        = DATA_W / 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              wr_req_valid,
    output logic              wr_req_ready,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  axi_prot_t         wr_req_prot,
    input  logic [DATA_W-1:0] wr_req_data,
    input  logic [STRB_W-1:0] wr_req_strb,
    output logic              wr_rsp_valid,
    input  logic              wr_rsp_ready,
    output logic [1:0]        wr_rsp_resp,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  axi_prot_t         rd_req_prot,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic [DATA_W-1:0] rd_rsp_data,
    output logic [1:0]        rd_rsp_resp,
    output logic [ADDR_W-1:0] awaddr,
    output axi_prot_t         awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output axi_prot_t         arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    ,
    output logic              wr_timeout,
    output logic              rd_timeout
`endif
);

    if ((MAX_OUT < 1) || (MAX_OUT > 15) || (TIMEOUT_CYCLES < 1) ||
        ((DATA_W != 32) && (DATA_W != 64))) begin : g_bad_params
        $error("axi4_lite_master_bridge: parameter out of range");
    end

    logic aw_pend, w_pend, ar_pend;
    logic wr_accept, rd_accept;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

    logic [OUT_CNT_W-1:0] wr_out_q, wr_out_d, rd_out_q, rd_out_d;

    logic              wr_rsp_valid_q, wr_rsp_valid_d;
    logic [1:0]        wr_rsp_resp_q, wr_rsp_resp_d;
    logic              rd_rsp_valid_q, rd_rsp_valid_d;
    logic [1:0]        rd_rsp_resp_q, rd_rsp_resp_d;
    logic [DATA_W-1:0] rd_rsp_data_q, rd_rsp_data_d;

    logic [ADDR_W+2:0]        aw_data, ar_data;
    logic [DATA_W+STRB_W-1:0] w_data;

    // Readies are gated by aresetn so they read 0 while reset is held.
    assign wr_req_ready = aresetn && !aw_pend && !w_pend && (wr_out_q < OUT_CNT_W'(MAX_OUT));
    assign rd_req_ready = aresetn && !ar_pend && (rd_out_q < OUT_CNT_W'(MAX_OUT));
    assign bready       = aresetn && !wr_rsp_valid_q;
    assign rready       = aresetn && !rd_rsp_valid_q;

    assign wr_accept = wr_req_valid && wr_req_ready;
    assign rd_accept = rd_req_valid && rd_req_ready;
    assign aw_hs     = aw_pend && awready;
    assign w_hs      = w_pend && wready;
    assign ar_hs     = ar_pend && arready;
    assign b_hs      = bvalid && bready;
    assign r_hs      = rvalid && rready;

    axi4_lite_hold_reg #(.WIDTH(ADDR_W + 3)) u_aw_reg (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (wr_accept),
        .load_data ({wr_req_prot, wr_req_addr}),
        .handshake (aw_hs),
        .pend      (aw_pend),
        .data      (aw_data)
    );

    axi4_lite_hold_reg #(.WIDTH(DATA_W + STRB_W)) u_w_reg (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (wr_accept),
        .load_data ({wr_req_strb, wr_req_data}),
        .handshake (w_hs),
        .pend      (w_pend),
        .data      (w_data)
    );

    axi4_lite_hold_reg #(.WIDTH(ADDR_W + 3)) u_ar_reg (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .load      (rd_accept),
        .load_data ({rd_req_prot, rd_req_addr}),
        .handshake (ar_hs),
        .pend      (ar_pend),
        .data      (ar_data)
    );

    assign awvalid = aw_pend;
    assign awaddr  = aw_data[ADDR_W-1:0];
    assign awprot  = aw_data[ADDR_W+2:ADDR_W];
    assign wvalid  = w_pend;
    assign wdata   = w_data[DATA_W-1:0];
    assign wstrb   = w_data[DATA_W+STRB_W-1:DATA_W];
    assign arvalid = ar_pend;
    assign araddr  = ar_data[ADDR_W-1:0];
    assign arprot  = ar_data[ADDR_W+2:ADDR_W];

    always_comb begin
        wr_out_d       = next_outstanding(wr_out_q, wr_accept, b_hs);
        rd_out_d       = next_outstanding(rd_out_q, rd_accept, r_hs);
        wr_rsp_valid_d = wr_rsp_valid_q;
        wr_rsp_resp_d  = wr_rsp_resp_q;
        rd_rsp_valid_d = rd_rsp_valid_q;
        rd_rsp_resp_d  = rd_rsp_resp_q;
        rd_rsp_data_d  = rd_rsp_data_q;
        // A B/R handshake only happens while the response slot is empty.
        if (b_hs) begin
            wr_rsp_valid_d = 1'b1;
            wr_rsp_resp_d  = bresp;
        end else if (wr_rsp_valid_q && wr_rsp_ready) begin
            wr_rsp_valid_d = 1'b0;
        end
        if (r_hs) begin
            rd_rsp_valid_d = 1'b1;
            rd_rsp_resp_d  = rresp;
            rd_rsp_data_d  = rdata;
        end else if (rd_rsp_valid_q && rd_rsp_ready) begin
            rd_rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_out_q       <= '0;
            rd_out_q       <= '0;
            wr_rsp_valid_q <= 1'b0;
            wr_rsp_resp_q  <= '0;
            rd_rsp_valid_q <= 1'b0;
            rd_rsp_resp_q  <= '0;
            rd_rsp_data_q  <= '0;
        end else begin
            wr_out_q       <= wr_out_d;
            rd_out_q       <= rd_out_d;
            wr_rsp_valid_q <= wr_rsp_valid_d;
            wr_rsp_resp_q  <= wr_rsp_resp_d;
            rd_rsp_valid_q <= rd_rsp_valid_d;
            rd_rsp_resp_q  <= rd_rsp_resp_d;
            rd_rsp_data_q  <= rd_rsp_data_d;
        end
    end

    assign wr_rsp_valid = wr_rsp_valid_q;
    assign wr_rsp_resp  = wr_rsp_resp_q;
    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_rsp_resp  = rd_rsp_resp_q;
    assign rd_rsp_data  = rd_rsp_data_q;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wr_to_cnt_q, wr_to_cnt_d, rd_to_cnt_q, rd_to_cnt_d;
    logic            wr_timeout_q, wr_timeout_d, rd_timeout_q, rd_timeout_d;

    // Counters saturate at the limit; flags are sticky until reset.
    always_comb begin
        wr_to_cnt_d = wr_to_cnt_q;
        rd_to_cnt_d = rd_to_cnt_q;
        if (b_hs || (wr_out_q == '0)) begin
            wr_to_cnt_d = '0;
        end else if (wr_to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            wr_to_cnt_d = wr_to_cnt_q + TO_W'(1);
        end
        if (r_hs || (rd_out_q == '0)) begin
            rd_to_cnt_d = '0;
        end else if (rd_to_cnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            rd_to_cnt_d = rd_to_cnt_q + TO_W'(1);
        end
        wr_timeout_d = wr_timeout_q || (wr_to_cnt_d == TO_W'(TIMEOUT_CYCLES));
        rd_timeout_d = rd_timeout_q || (rd_to_cnt_d == TO_W'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_to_cnt_q  <= '0;
            rd_to_cnt_q  <= '0;
            wr_timeout_q <= 1'b0;
            rd_timeout_q <= 1'b0;
        end else begin
            wr_to_cnt_q  <= wr_to_cnt_d;
            rd_to_cnt_q  <= rd_to_cnt_d;
            wr_timeout_q <= wr_timeout_d;
            rd_timeout_q <= rd_timeout_d;
        end
    end

    assign wr_timeout = wr_timeout_q;
    assign rd_timeout = rd_timeout_q;
`endif

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Bench for axi4_lite_master_bridge: transaction-queue model checked every cycle plus directed cases.
module tb_axi4_lite_master_bridge;

    localparam int MAX_OUT = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        wr_req_valid = 1'b0, wr_req_ready;
    logic [31:0] wr_req_addr = '0;
    logic [2:0]  wr_req_prot = '0;
    logic [31:0] wr_req_data = '0;
    logic [3:0]  wr_req_strb = '0;
    logic        wr_rsp_valid, wr_rsp_ready = 1'b1;
    logic [1:0]  wr_rsp_resp;
    logic        rd_req_valid = 1'b0, rd_req_ready;
    logic [31:0] rd_req_addr = '0;
    logic [2:0]  rd_req_prot = '0;
    logic        rd_rsp_valid, rd_rsp_ready = 1'b1;
    logic [31:0] rd_rsp_data;
    logic [1:0]  rd_rsp_resp;
    logic [31:0] awaddr, araddr, wdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b1, wvalid, wready = 1'b1;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b1;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0, rready;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    logic        wr_timeout, rd_timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axi4_lite_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_prot(wr_req_prot),
        .wr_req_data(wr_req_data), .wr_req_strb(wr_req_strb),
        .wr_rsp_valid(wr_rsp_valid), .wr_rsp_ready(wr_rsp_ready), .wr_rsp_resp(wr_rsp_resp),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_prot(rd_req_prot),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
        .rd_rsp_data(rd_rsp_data), .rd_rsp_resp(rd_rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
        , .wr_timeout(wr_timeout), .rd_timeout(rd_timeout)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel is a queue of transactions the bridge still owes.
    logic [34:0] m_aw[$];
    logic [35:0] m_w[$];
    logic [34:0] m_ar[$];
    logic [1:0]  m_wrsp[$];
    logic [33:0] m_rrsp[$];
    int          m_wr_out = 0;
    int          m_rd_out = 0;

    function automatic bit m_wr_ready();
        return aresetn && m_aw.size() == 0 && m_w.size() == 0 && m_wr_out < MAX_OUT;
    endfunction

    function automatic bit m_rd_ready();
        return aresetn && m_ar.size() == 0 && m_rd_out < MAX_OUT;
    endfunction

    always @(posedge aclk or negedge aresetn) begin : model
        bit acc_w, acc_r, aw_hs, w_hs, ar_hs, b_hs, r_hs, wdone, rdone;
        if (!aresetn) begin
            m_aw.delete(); m_w.delete(); m_ar.delete(); m_wrsp.delete(); m_rrsp.delete();
            m_wr_out = 0;
            m_rd_out = 0;
        end else begin
            acc_w = wr_req_valid && m_wr_ready();
            acc_r = rd_req_valid && m_rd_ready();
            aw_hs = m_aw.size() != 0 && awready;
            w_hs  = m_w.size() != 0 && wready;
            ar_hs = m_ar.size() != 0 && arready;
            b_hs  = bvalid && m_wrsp.size() == 0;
            r_hs  = rvalid && m_rrsp.size() == 0;
            wdone = m_wrsp.size() != 0 && wr_rsp_ready;
            rdone = m_rrsp.size() != 0 && rd_rsp_ready;
            if (aw_hs) void'(m_aw.pop_front());
            if (w_hs)  void'(m_w.pop_front());
            if (ar_hs) void'(m_ar.pop_front());
            if (wdone) void'(m_wrsp.pop_front());
            if (rdone) void'(m_rrsp.pop_front());
            if (b_hs)  m_wrsp.push_back(bresp);
            if (r_hs)  m_rrsp.push_back({rresp, rdata});
            if (acc_w) begin
                m_aw.push_back({wr_req_prot, wr_req_addr});
                m_w.push_back({wr_req_strb, wr_req_data});
            end
            if (acc_r) m_ar.push_back({rd_req_prot, rd_req_addr});
            m_wr_out = m_wr_out + int'(acc_w) - int'(b_hs);
            m_rd_out = m_rd_out + int'(acc_r) - int'(r_hs);
            if (m_wr_out < 0) m_wr_out = 0;
            if (m_rd_out < 0) m_rd_out = 0;
        end
    end

    always @(negedge aclk) begin : compare
        chk("awvalid", awvalid, m_aw.size() != 0);
        if (m_aw.size() != 0) begin
            chk("awaddr", awaddr, m_aw[0][31:0]);
            chk("awprot", awprot, m_aw[0][34:32]);
        end
        chk("wvalid", wvalid, m_w.size() != 0);
        if (m_w.size() != 0) begin
            chk("wdata", wdata, m_w[0][31:0]);
            chk("wstrb", wstrb, m_w[0][35:32]);
        end
        chk("arvalid", arvalid, m_ar.size() != 0);
        if (m_ar.size() != 0) begin
            chk("araddr", araddr, m_ar[0][31:0]);
            chk("arprot", arprot, m_ar[0][34:32]);
        end
        chk("bready", bready, aresetn && m_wrsp.size() == 0);
        chk("rready", rready, aresetn && m_rrsp.size() == 0);
        chk("wr_rsp_valid", wr_rsp_valid, m_wrsp.size() != 0);
        if (m_wrsp.size() != 0) chk("wr_rsp_resp", wr_rsp_resp, m_wrsp[0]);
        chk("rd_rsp_valid", rd_rsp_valid, m_rrsp.size() != 0);
        if (m_rrsp.size() != 0) begin
            chk("rd_rsp_data", rd_rsp_data, m_rrsp[0][31:0]);
            chk("rd_rsp_resp", rd_rsp_resp, m_rrsp[0][33:32]);
        end
        chk("wr_req_ready", wr_req_ready, m_wr_ready());
        chk("rd_req_ready", rd_req_ready, m_rd_ready());
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p);
        bit seen;
        seen = 0;
        wr_req_addr = a; wr_req_data = d; wr_req_strb = s; wr_req_prot = p;
        wr_req_valid = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            seen = wr_req_ready;
            tick();
        end
        wr_req_valid = 1'b0;
        chk("wr_cmd_accepted", seen, 1'b1);
    endtask

    task automatic rd_cmd(input logic [31:0] a, input logic [2:0] p);
        bit seen;
        seen = 0;
        rd_req_addr = a; rd_req_prot = p;
        rd_req_valid = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            seen = rd_req_ready;
            tick();
        end
        rd_req_valid = 1'b0;
        chk("rd_cmd_accepted", seen, 1'b1);
    endtask

    task automatic b_ret(input logic [1:0] r);
        bit seen;
        seen = 0;
        bvalid = 1'b1; bresp = r;
        for (int i = 0; i < 50 && !seen; i++) begin
            seen = bready;
            tick();
        end
        bvalid = 1'b0;
        chk("b_handshake", seen, 1'b1);
    endtask

    task automatic r_ret(input logic [31:0] d, input logic [1:0] r);
        bit seen;
        seen = 0;
        rvalid = 1'b1; rdata = d; rresp = r;
        for (int i = 0; i < 50 && !seen; i++) begin
            seen = rready;
            tick();
        end
        rvalid = 1'b0;
        chk("r_handshake", seen, 1'b1);
    endtask

    task automatic fill(input int cycles, output int acc);
        acc = 0;
        wr_req_valid = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            wr_req_addr = 32'(32'h100 + 4 * i);
            wr_req_data = 32'(i);
            wr_req_strb = 4'hF;
            if (wr_req_ready) acc++;
            tick();
        end
        wr_req_valid = 1'b0;
    endtask

    task automatic drain_b(input int n);
        for (int i = 0; i < n; i++) b_ret(2'b00);
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc;
        #3;
        chk("reset_awvalid", awvalid, 1'b0);
        chk("reset_wr_req_ready", wr_req_ready, 1'b0);
        chk("reset_bready", bready, 1'b0);
        chk("reset_rd_rsp_data", rd_rsp_data, 32'h0);
        #4 aresetn = 1'b1;
        tick();

        // Basic write, always-ready slave, B two cycles after accept.
        wr_cmd(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000);
        chk("t1_awvalid", awvalid, 1'b1);
        chk("t1_wvalid", wvalid, 1'b1);
        chk("t1_awaddr", awaddr, 32'h10);
        chk("t1_wdata", wdata, 32'hDEAD_BEEF);
        tick();
        chk("t1_awvalid_done", awvalid, 1'b0);
        chk("t1_ready_again", wr_req_ready, 1'b1);
        b_ret(2'b00);
        chk("t1_rsp_valid", wr_rsp_valid, 1'b1);
        chk("t1_rsp_resp", wr_rsp_resp, 2'b00);
        chk("t1_bready_low", bready, 1'b0);
        tick();
        chk("t1_rsp_cleared", wr_rsp_valid, 1'b0);

        // AW stalled three cycles, W immediate.
        awready = 1'b0;
        wr_cmd(32'h0000_0044, 32'hA5A5_0001, 4'h3, 3'b010);
        chk("t2_awvalid_c1", awvalid, 1'b1);
        tick();
        chk("t2_wvalid_dropped", wvalid, 1'b0);
        chk("t2_awvalid_c2", awvalid, 1'b1);
        chk("t2_awaddr_c2", awaddr, 32'h44);
        chk("t2_awprot_c2", awprot, 3'b010);
        chk("t2_ready_blocked", wr_req_ready, 1'b0);
        tick();
        chk("t2_awaddr_c3", awaddr, 32'h44);
        awready = 1'b1;
        tick();
        chk("t2_awvalid_done", awvalid, 1'b0);
        chk("t2_ready_again", wr_req_ready, 1'b1);
        b_ret(2'b10);
        chk("t2_rsp_slverr", wr_rsp_resp, 2'b10);
        tick();

        // Outstanding limit with B withheld.
        fill(20, acc);
        chk("t3_accepted", 32'(acc), 32'd4);
        chk("t3_ready_full", wr_req_ready, 1'b0);
        b_ret(2'b00);
        chk("t3_ready_after_b", wr_req_ready, 1'b1);
        drain_b(3);

        // Stray B with nothing outstanding: captured, count stays at 0.
        b_ret(2'b11);
        chk("t3_stray_resp", wr_rsp_resp, 2'b11);
        tick();
        fill(20, acc);
        chk("t3_after_stray", 32'(acc), 32'd4);
        drain_b(4);

        // Accept and B in the same cycle leave the count unchanged.
        wr_cmd(32'h0000_0000, 32'h0000_0000, 4'h0, 3'b000);
        tick();
        wr_req_addr = 32'h8; wr_req_valid = 1'b1;
        bvalid = 1'b1; bresp = 2'b01;
        chk("t3b_both_ready", wr_req_ready && bready, 1'b1);
        tick();
        wr_req_valid = 1'b0; bvalid = 1'b0;
        tick();
        fill(20, acc);
        chk("t3b_accepted", 32'(acc), 32'd3);
        drain_b(4);

        // Read with response held by the local side.
        rd_rsp_ready = 1'b0;
        rd_cmd(32'h0000_0020, 3'b001);
        chk("t4_arvalid", arvalid, 1'b1);
        chk("t4_araddr", araddr, 32'h20);
        tick();
        chk("t4_arvalid_done", arvalid, 1'b0);
        r_ret(32'h1234_5678, 2'b10);
        for (int i = 0; i < 5; i++) begin
            chk("t4_rready_low", rready, 1'b0);
            chk("t4_rsp_valid", rd_rsp_valid, 1'b1);
            chk("t4_rsp_data", rd_rsp_data, 32'h1234_5678);
            chk("t4_rsp_resp", rd_rsp_resp, 2'b10);
            tick();
        end
        rd_rsp_ready = 1'b1;
        tick();
        chk("t4_rsp_cleared", rd_rsp_valid, 1'b0);
        chk("t4_rready_back", rready, 1'b1);

        // Reset mid-transaction with two writes outstanding.
        wr_cmd(32'h0000_0200, 32'h1, 4'hF, 3'b000);
        tick();
        awready = 1'b0;
        wr_cmd(32'h0000_0204, 32'h2, 4'hF, 3'b000);
        chk("t5_awvalid_pre", awvalid, 1'b1);
        #1 aresetn = 1'b0;
        #1;
        chk("t5_awvalid_rst", awvalid, 1'b0);
        chk("t5_wvalid_rst", wvalid, 1'b0);
        chk("t5_awaddr_rst", awaddr, 32'h0);
        chk("t5_ready_rst", wr_req_ready, 1'b0);
        @(posedge aclk);
        #2 aresetn = 1'b1;
        awready = 1'b1;
        tick();
        chk("t5_ready_after", wr_req_ready, 1'b1);
        fill(20, acc);
        chk("t5_accepted", 32'(acc), 32'd4);
        drain_b(4);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
        rd_cmd(32'h0000_0030, 3'b000);
        repeat (15) tick();
        chk("t6_rd_timeout_early", rd_timeout, 1'b0);
        tick();
        chk("t6_rd_timeout", rd_timeout, 1'b1);
        chk("t6_wr_timeout", wr_timeout, 1'b0);
        r_ret(32'h0, 2'b00);
        tick();
        chk("t6_rd_timeout_sticky", rd_timeout, 1'b1);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
